// File: rtl/cla_pkg.sv
// Shared definitions for the Wishbone front end of the 4-bit carry-lookahead adder:
// register offsets, STATUS bit positions and the sequencer state encoding.
package cla_pkg;

  localparam int CLA_WIDTH = 4;

  // Word offsets within the 16-byte window, taken from wbs_adr_i[3:2]
  localparam logic [1:0] OFF_OPERAND = 2'd0;
  localparam logic [1:0] OFF_RESULT  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_CTRL    = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_wb_sequencer.sv
// Wishbone slave that drives operands into an external combinational adder, waits a
// fixed settle interval, then captures the sum into a readable RESULT register.
module cla_wb_sequencer
  import cla_pkg::*;
#(
  parameter int          WIDTH     = CLA_WIDTH,
  parameter int          SETTLE    = 2,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] cla_a_o,
  output logic [WIDTH-1:0] cla_b_o,
  output logic             cla_cin_o,
  input  logic [WIDTH-1:0] cla_s_i,
  input  logic             cla_cout_i,
  output logic             irq_o
);

  state_e           state_q,    state_d;
  logic [3:0]       cnt_q,      cnt_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic             cin_q,      cin_d;
  logic [WIDTH-1:0] res_s_q,    res_s_d;
  logic             res_cout_q, res_cout_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic             irq_en_q,   irq_en_d;
  logic             irq_q,      irq_d;
  logic             ack_q,      ack_d;
  logic [31:0]      dat_q,      dat_d;

  logic       hit, accept, wr, rd, busy, op_wr, launch;
  logic [1:0] off;

  // Bits of the bus that carry no register field.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:2*WIDTH+1], wbs_sel_i[3:2]};

  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    hit    = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    accept = wbs_stb_i && wbs_cyc_i && !ack_q && hit;
    wr     = accept && wbs_we_i;
    rd     = accept && !wbs_we_i;
    off    = wbs_adr_i[3:2];
    busy   = (state_q != ST_IDLE);
    op_wr  = wr && (off == OFF_OPERAND) && (wbs_sel_i != 4'b0000);
    launch = op_wr && !busy;

    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    res_s_d    = res_s_q;
    res_cout_d = res_cout_q;
    done_d     = done_q;
    err_d      = err_q;
    irq_en_d   = irq_en_q;
    irq_d      = done_q && irq_en_q;
    ack_d      = accept;
    dat_d      = '0;

    // Read data reflects register contents before this edge's side effects.
    if (rd) begin
      unique case (off)
        OFF_OPERAND: dat_d = {{(31-2*WIDTH){1'b0}}, cin_q, b_q, a_q};
        OFF_RESULT:  dat_d = {{(31-WIDTH){1'b0}}, res_cout_q, res_s_q};
        OFF_STATUS:  dat_d = {29'b0, err_q, done_q, busy};
        OFF_CTRL:    dat_d = {31'b0, irq_en_q};
        default:     dat_d = '0;
      endcase
    end

    // Clears are applied before sets below so a same-cycle set wins.
    if (wr && (off == OFF_STATUS) && wbs_sel_i[0]) begin
      if (wbs_dat_i[STAT_DONE]) done_d = 1'b0;
      if (wbs_dat_i[STAT_ERR])  err_d  = 1'b0;
    end
    if (wr && (off == OFF_CTRL) && wbs_sel_i[0]) irq_en_d = wbs_dat_i[0];
    if (op_wr && busy) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          if (wbs_sel_i[0]) begin
            a_d = wbs_dat_i[WIDTH-1:0];
            b_d = wbs_dat_i[2*WIDTH-1:WIDTH];
          end
          if (wbs_sel_i[1]) cin_d = wbs_dat_i[2*WIDTH];
          cnt_d   = 4'(SETTLE - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_CAPTURE: begin
        res_s_d    = cla_s_i;
        res_cout_d = cla_cout_i;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      res_s_q    <= '0;
      res_cout_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      res_s_q    <= res_s_d;
      res_cout_q <= res_cout_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign cla_a_o   = a_q;
  assign cla_b_o   = b_q;
  assign cla_cin_o = cin_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_cla_wb_sequencer.sv
// Directed bench for cla_wb_sequencer: a behavioural adder stands in for the external
// cla, and each task drives one scenario over Wishbone and checks hand-computed values.
module tb_cla_wb_sequencer;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] A_OPER   = BASE + 32'h0;
  localparam logic [31:0] A_RESULT = BASE + 32'h4;
  localparam logic [31:0] A_STATUS = BASE + 32'h8;
  localparam logic [31:0] A_CTRL   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = '0, adr = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [3:0]  cla_a, cla_b, cla_s;
  logic        cla_cin, cla_cout, irq;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  // Stand-in for the combinational carry-lookahead adder.
  assign {cla_cout, cla_s} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  cla_wb_sequencer #(.WIDTH(4), .SETTLE(2), .ADDR_BASE(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (wdat),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .cla_a_o   (cla_a),
    .cla_b_o   (cla_b),
    .cla_cin_o (cla_cin),
    .cla_s_i   (cla_s),
    .cla_cout_i(cla_cout),
    .irq_o     (irq)
  );

  // Called 1ns after a rising edge; returns 1ns after the edge where ack is seen.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output bit acked);
    adr = a; we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
    acked = 1'b0; r = '0;
    for (int i = 0; i < 6 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; r = rdat; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s = 4'hF);
    logic [31:0] r;
    bit          acked;
    bus(a, 1'b1, d, s, r, acked);
    n_asserts++;
    if (acked !== 1'b1) begin
      $display("FAIL write_ack adr=%h: got no ack, expected ack", a);
      n_fails++;
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    bit acked;
    bus(a, 1'b0, 32'h0, 4'hF, r, acked);
    n_asserts++;
    if (acked !== 1'b1) begin
      $display("FAIL read_ack adr=%h: got no ack, expected ack", a);
      n_fails++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_asserts++;
    if ({cla_a, cla_b, cla_cin, irq, ack, rdat} !== '0) begin
      $display("FAIL reset_outputs: got a=%h b=%h cin=%b irq=%b ack=%b dat=%h, expected all 0",
               cla_a, cla_b, cla_cin, irq, ack, rdat);
      n_fails++;
    end
    for (int i = 0; i < 4; i++) begin
      wb_read(BASE + 32'(4 * i), r);
      n_asserts++;
      if (r !== 32'h0) begin
        $display("FAIL reset_reg%0d: got %h, expected 0", i, r);
        n_fails++;
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    wb_write(A_OPER, 32'h17A);          // accepted at edge N
    wb_read(A_STATUS, r);               // accepted N+2, state after N+1
    n_asserts++;
    if (r !== 32'h1) begin
      $display("FAIL basic_busy: got status %h, expected 1", r); n_fails++;
    end
    wb_read(A_STATUS, r);               // accepted N+4, state after N+3
    n_asserts++;
    if (r !== 32'h2) begin
      $display("FAIL basic_done: got status %h, expected 2", r); n_fails++;
    end
    n_asserts++;
    if ({cla_cin, cla_b, cla_a} !== 9'h17A) begin
      $display("FAIL basic_operands: got %h, expected 17a", {cla_cin, cla_b, cla_a});
      n_fails++;
    end
    wb_read(A_RESULT, r);
    n_asserts++;
    if (r !== 32'h12) begin
      $display("FAIL basic_result: got %h, expected 12", r); n_fails++;
    end
    @(posedge clk); #1;
    n_asserts++;
    if (ack !== 1'b0 || rdat !== 32'h0) begin
      $display("FAIL ack_pulse: got ack=%b dat=%h, expected ack=0 dat=0", ack, rdat);
      n_fails++;
    end
    wb_write(A_STATUS, 32'h2);
    wb_read(A_STATUS, r);
    n_asserts++;
    if (r !== 32'h0) begin
      $display("FAIL done_w1c: got status %h, expected 0", r); n_fails++;
    end
  endtask

  task automatic test_busy_edge();
    logic [31:0] r;
    wb_write(A_OPER, 32'h17A);          // edge N
    repeat (2) @(posedge clk); #1;
    wb_read(A_STATUS, r);               // accepted N+3, state after N+2 (capture)
    n_asserts++;
    if (r !== 32'h1) begin
      $display("FAIL busy_capture_cycle: got status %h, expected 1", r); n_fails++;
    end
    wb_write(A_STATUS, 32'h2);
  endtask

  task automatic test_irq();
    logic [31:0] r;
    wb_write(A_CTRL, 32'h1);
    wb_read(A_CTRL, r);
    n_asserts++;
    if (r !== 32'h1) begin
      $display("FAIL ctrl_rw: got %h, expected 1", r); n_fails++;
    end
    wb_write(A_OPER, 32'h0FF);          // edge N, done after N+3
    repeat (3) @(posedge clk); #1;
    n_asserts++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_early: got %b, expected 0", irq); n_fails++;
    end
    @(posedge clk); #1;
    n_asserts++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_rise: got %b, expected 1", irq); n_fails++;
    end
    wb_read(A_RESULT, r);
    n_asserts++;
    if (r !== 32'h1E) begin
      $display("FAIL irq_result: got %h, expected 1e", r); n_fails++;
    end
    wb_write(A_STATUS, 32'h2);
    n_asserts++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_hold: got %b, expected 1", irq); n_fails++;
    end
    @(posedge clk); #1;
    n_asserts++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_fall: got %b, expected 0", irq); n_fails++;
    end
    wb_write(A_CTRL, 32'h0);
  endtask

  task automatic test_busy_write();
    logic [31:0] r;
    wb_write(A_OPER, 32'h123);          // edge N
    wb_write(A_OPER, 32'h011);          // accepted N+2 while busy
    n_asserts++;
    if ({cla_cin, cla_b, cla_a} !== 9'h123) begin
      $display("FAIL busy_wr_operands: got %h, expected 123", {cla_cin, cla_b, cla_a});
      n_fails++;
    end
    repeat (3) @(posedge clk); #1;
    wb_read(A_RESULT, r);
    n_asserts++;
    if (r !== 32'h06) begin
      $display("FAIL busy_wr_result: got %h, expected 06", r); n_fails++;
    end
    wb_read(A_STATUS, r);
    n_asserts++;
    if (r !== 32'h6) begin
      $display("FAIL busy_wr_err: got status %h, expected 6", r); n_fails++;
    end
    wb_read(A_OPER, r);
    n_asserts++;
    if (r !== 32'h123) begin
      $display("FAIL busy_wr_oper_reg: got %h, expected 123", r); n_fails++;
    end
    wb_write(A_STATUS, 32'h4);
    wb_read(A_STATUS, r);
    n_asserts++;
    if (r !== 32'h2) begin
      $display("FAIL err_w1c: got status %h, expected 2", r); n_fails++;
    end
  endtask

  task automatic test_w1c_capture();
    logic [31:0] r;
    // Only sel[0]: A/B become F/F, cin keeps 1 from the previous operand.
    wb_write(A_OPER, 32'h0FF, 4'b0001); // edge N
    repeat (2) @(posedge clk); #1;
    wb_write(A_STATUS, 32'h2);          // accepted at N+3, the capture edge
    wb_read(A_STATUS, r);
    n_asserts++;
    if (r !== 32'h2) begin
      $display("FAIL w1c_vs_capture: got status %h, expected 2", r); n_fails++;
    end
    wb_read(A_OPER, r);
    n_asserts++;
    if (r !== 32'h1FF) begin
      $display("FAIL sel_partial: got operand %h, expected 1ff", r); n_fails++;
    end
    wb_read(A_RESULT, r);
    n_asserts++;
    if (r !== 32'h1F) begin
      $display("FAIL sel_partial_result: got %h, expected 1f", r); n_fails++;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    bit          acked;
    wb_write(A_CTRL, 32'h1);            // done is 1, so irq goes high
    wb_write(A_OPER, 32'h155);          // edge N
    rst = 1'b1;
    @(posedge clk); #1;                 // reset at N+1, during SETTLE
    rst = 1'b0;
    n_asserts++;
    if ({cla_a, cla_b, cla_cin, irq, ack, rdat} !== '0) begin
      $display("FAIL midop_reset_outputs: got a=%h b=%h cin=%b irq=%b ack=%b dat=%h, expected all 0",
               cla_a, cla_b, cla_cin, irq, ack, rdat);
      n_fails++;
    end
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      wb_read(BASE + 32'(4 * i), r);
      n_asserts++;
      if (r !== 32'h0) begin
        $display("FAIL midop_reg%0d: got %h, expected 0", i, r); n_fails++;
      end
    end
    bus(BASE + 32'h10, 1'b0, 32'h0, 4'hF, r, acked);
    n_asserts++;
    if (acked !== 1'b0) begin
      $display("FAIL off_window: got ack, expected none"); n_fails++;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_busy_edge();
    test_irq();
    test_busy_write();
    test_w1c_capture();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
